branch_resolve_unit: RTL and testbench

- Resolve-side counterpart of the IF-stage BTB/2-bit-counter predictor.
- Holds every prediction issued at IF in an in-order queue and compares each against the actual outcome when the instruction resolves.
- On a mismatch, issues a one-cycle flush with the redirect PC.
- Sends a valid/ready training request (index, tag, taken, target) back to the predictor and keeps saturating branch and mispredict statistics.

---
 rtl/branch_resolve_unit_if.sv | 48 ++++
 rtl/branch_resolve_unit.sv | 125 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Bundle of every non-clock signal of branch_resolve_unit.
//   slave  : the resolve unit's view (predictions/resolves/upd_ready in,
//            pred_full/resolve_ready/flush/redirect/update/stats out)
//   master : the environment's view (directions reversed)
interface branch_resolve_unit_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned IDX_W     = 8
);
  logic                       pred_valid;
  logic [WORD_SIZE-1:0]       pred_PC;
  logic [WORD_SIZE-1:0]       pred_next_PC;
  logic                       pred_full;
  logic                       resolve_valid;
  logic                       resolve_ready;
  logic [WORD_SIZE-1:0]       resolve_PC;
  logic                       resolve_is_branch;
  logic                       resolve_taken;
  logic [WORD_SIZE-1:0]       resolve_target;
  logic                       flush;
  logic [WORD_SIZE-1:0]       redirect_PC;
  logic                       upd_valid;
  logic                       upd_ready;
  logic [IDX_W-1:0]           upd_index;
  logic [WORD_SIZE-IDX_W-1:0] upd_tag;
  logic                       upd_taken;
  logic [WORD_SIZE-1:0]       upd_target;
  logic                       seq_err;
  logic [WORD_SIZE-1:0]       branch_count;
  logic [WORD_SIZE-1:0]       mispredict_count;

  modport slave (
    input  pred_valid, pred_PC, pred_next_PC,
    input  resolve_valid, resolve_PC, resolve_is_branch, resolve_taken, resolve_target,
    input  upd_ready,
    output pred_full, resolve_ready, flush, redirect_PC,
    output upd_valid, upd_index, upd_tag, upd_taken, upd_target,
    output seq_err, branch_count, mispredict_count
  );

  modport master (
    output pred_valid, pred_PC, pred_next_PC,
    output resolve_valid, resolve_PC, resolve_is_branch, resolve_taken, resolve_target,
    output upd_ready,
    input  pred_full, resolve_ready, flush, redirect_PC,
    input  upd_valid, upd_index, upd_tag, upd_taken, upd_target,
    input  seq_err, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolve-side checker for the IF-stage branch predictor. Queues every
// prediction in order, compares the head against the actual outcome on
// resolve, flushes with the redirect PC on a mismatch, and sends training
// requests back to the predictor over a valid/ready channel.
// Ports: clk, reset_n (async active-low), bus (branch_resolve_unit_if.slave).
module branch_resolve_unit #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned IDX_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  branch_resolve_unit_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] next_pc;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [CNT_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  entry_t               head;
  logic                 ready;
  logic                 accept;
  logic [WORD_SIZE-1:0] actual_next;
  logic                 seq_bad;
  logic                 mispredict;
  logic                 pop;
  logic                 push;
  logic                 clear;

  // Resolve evaluation against the queue head.
  always_comb begin
    count       = wr_ptr - rd_ptr;
    full        = (count == CNT_W'(DEPTH));
    empty       = (count == '0);
    head        = mem[rd_ptr[PTR_W-1:0]];
    ready       = !bus.upd_valid || bus.upd_ready;
    accept      = bus.resolve_valid && ready;
    actual_next = bus.resolve_taken ? bus.resolve_target
                                    : bus.resolve_PC + WORD_SIZE'(1);
    seq_bad     = empty || (head.pc != bus.resolve_PC);
    mispredict  = seq_bad || (head.next_pc != actual_next);
    pop         = accept && !empty;
    clear       = accept && mispredict;
    // A pop frees the slot, so a full queue can still take a push that cycle.
    push        = bus.pred_valid && (!full || pop) && !clear;
  end

  assign bus.pred_full     = full;
  assign bus.resolve_ready = ready;

  // Queue storage; contents need no reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= '{pc: bus.pred_PC, next_pc: bus.pred_next_PC};
  end

  // Queue pointers; a mispredict squashes everything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
      if (push) wr_ptr <= wr_ptr + CNT_W'(1);
    end
  end

  // Flush pulse and redirect target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.flush       <= 1'b0;
      bus.redirect_PC <= '0;
    end else begin
      bus.flush <= clear;
      if (clear) bus.redirect_PC <= actual_next;
    end
  end

  // Training request register; a fresh load wins over a handshake drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.upd_valid  <= 1'b0;
      bus.upd_index  <= '0;
      bus.upd_tag    <= '0;
      bus.upd_taken  <= 1'b0;
      bus.upd_target <= '0;
    end else if (accept && bus.resolve_is_branch) begin
      bus.upd_valid  <= 1'b1;
      bus.upd_index  <= bus.resolve_PC[IDX_W-1:0];
      bus.upd_tag    <= bus.resolve_PC[WORD_SIZE-1:IDX_W];
      bus.upd_taken  <= bus.resolve_taken;
      bus.upd_target <= bus.resolve_target;
    end else if (bus.upd_valid && bus.upd_ready) begin
      bus.upd_valid  <= 1'b0;
    end
  end

  // Sticky sequencing error and saturating statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.seq_err          <= 1'b0;
      bus.branch_count     <= '0;
      bus.mispredict_count <= '0;
    end else begin
      if (accept && seq_bad) bus.seq_err <= 1'b1;
      if (accept && bus.resolve_is_branch && (bus.branch_count != '1))
        bus.branch_count <= bus.branch_count + WORD_SIZE'(1);
      if (clear && (bus.mispredict_count != '1))
        bus.mispredict_count <= bus.mispredict_count + WORD_SIZE'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed stimulus, a queue-based reference
// model checked every cycle, plus literal expectations at key points.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  bit   chk_on = 1'b0;
  int   total = 0;
  int   bad = 0;

  branch_resolve_unit_if #(.WORD_SIZE(16), .IDX_W(8)) bus ();

  branch_resolve_unit #(.WORD_SIZE(16), .DEPTH(DEPTH), .IDX_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct { logic [15:0] pc; logic [15:0] nx; } pe_t;
  pe_t         mq[$];
  bit          m_flush = 0;
  logic [15:0] m_redir = '0;
  bit          m_uv = 0;
  logic [15:0] m_upc = '0;
  bit          m_tk = 0;
  logic [15:0] m_tgt = '0;
  bit          m_seq = 0;
  int          m_bc = 0;
  int          m_mc = 0;
  bit          acc, seqb, mis, popped;
  logic [15:0] an;
  pe_t         e;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_flush = 0; m_redir = '0; m_uv = 0; m_upc = '0; m_tk = 0; m_tgt = '0;
      m_seq = 0; m_bc = 0; m_mc = 0;
    end else begin
      acc  = bus.resolve_valid && (!m_uv || bus.upd_ready);
      an   = bus.resolve_taken ? bus.resolve_target : bus.resolve_PC + 16'd1;
      seqb = (mq.size() == 0) || (mq[0].pc != bus.resolve_PC);
      mis  = seqb || (mq[0].nx != an);
      m_flush = acc && mis;
      if (acc && mis) m_redir = an;
      if (acc && bus.resolve_is_branch) begin
        m_uv = 1; m_upc = bus.resolve_PC; m_tk = bus.resolve_taken; m_tgt = bus.resolve_target;
      end else if (m_uv && bus.upd_ready) m_uv = 0;
      if (acc && seqb) m_seq = 1;
      if (acc && bus.resolve_is_branch && m_bc < 65535) m_bc++;
      if (acc && mis && m_mc < 65535) m_mc++;
      if (acc && mis) mq.delete();
      else begin
        popped = 0;
        if (acc && mq.size() > 0) begin void'(mq.pop_front()); popped = 1; end
        if (bus.pred_valid && (mq.size() < DEPTH)) begin
          e.pc = bus.pred_PC; e.nx = bus.pred_next_PC;
          mq.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("pred_full", 32'(bus.pred_full), 32'(mq.size() == DEPTH));
      check("resolve_ready", 32'(bus.resolve_ready), 32'(!m_uv || bus.upd_ready));
      check("flush", 32'(bus.flush), 32'(m_flush));
      if (m_flush) check("redirect_PC", 32'(bus.redirect_PC), 32'(m_redir));
      check("upd_valid", 32'(bus.upd_valid), 32'(m_uv));
      if (m_uv) begin
        check("upd_index", 32'(bus.upd_index), 32'(m_upc % 256));
        check("upd_tag", 32'(bus.upd_tag), 32'(m_upc / 256));
        check("upd_taken", 32'(bus.upd_taken), 32'(m_tk));
        check("upd_target", 32'(bus.upd_target), 32'(m_tgt));
      end
      check("seq_err", 32'(bus.seq_err), 32'(m_seq));
      check("branch_count", 32'(bus.branch_count), 32'(m_bc));
      check("mispredict_count", 32'(bus.mispredict_count), 32'(m_mc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pred_valid = 0; bus.pred_PC = '0; bus.pred_next_PC = '0;
    bus.resolve_valid = 0; bus.resolve_PC = '0; bus.resolve_is_branch = 0;
    bus.resolve_taken = 0; bus.resolve_target = '0;
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] nx);
    bus.pred_valid = 1; bus.pred_PC = pc; bus.pred_next_PC = nx;
  endtask

  task automatic resolve(input logic [15:0] pc, input bit br, input bit tk, input logic [15:0] tgt);
    bus.resolve_valid = 1; bus.resolve_PC = pc; bus.resolve_is_branch = br;
    bus.resolve_taken = tk; bus.resolve_target = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.upd_ready = 1;
    #2 reset_n = 0;
    #1 chk_on = 1;
    #1;
    check("rst_pred_full", 32'(bus.pred_full), 32'd0);
    check("rst_resolve_ready", 32'(bus.resolve_ready), 32'd1);
    check("rst_redirect", 32'(bus.redirect_PC), 32'd0);
    step(); step();
    reset_n = 1;
    step();

    // 1: correct non-branch resolve
    push(16'h0010, 16'h0011); step(); idle();
    resolve(16'h0010, 0, 0, 16'h0000); step(); idle();
    check("t1_flush", 32'(bus.flush), 32'd0);
    check("t1_bc", 32'(bus.branch_count), 32'd0);
    check("t1_uv", 32'(bus.upd_valid), 32'd0);

    // 2: taken branch mispredicted
    push(16'h0020, 16'h0021); step(); idle();
    resolve(16'h0020, 1, 1, 16'h0030); step(); idle();
    check("t2_flush", 32'(bus.flush), 32'd1);
    check("t2_redirect", 32'(bus.redirect_PC), 32'h0030);
    check("t2_uv", 32'(bus.upd_valid), 32'd1);
    check("t2_index", 32'(bus.upd_index), 32'h20);
    check("t2_tag", 32'(bus.upd_tag), 32'h00);
    check("t2_taken", 32'(bus.upd_taken), 32'd1);
    check("t2_target", 32'(bus.upd_target), 32'h0030);
    check("t2_mc", 32'(bus.mispredict_count), 32'd1);
    step();
    check("t2_flush_end", 32'(bus.flush), 32'd0);
    check("t2_uv_drain", 32'(bus.upd_valid), 32'd0);

    // 3: fill, overflow push ignored, pop+push while full
    for (int i = 0; i < 4; i++) begin
      push(16'h0040 + 16'(i), 16'h0041 + 16'(i)); step();
    end
    check("t3_full", 32'(bus.pred_full), 32'd1);
    push(16'h0050, 16'h0051); step();
    push(16'h0044, 16'h0045); resolve(16'h0040, 0, 0, 16'h0000); step(); idle();
    check("t3_full_kept", 32'(bus.pred_full), 32'd1);
    check("t3_noflush", 32'(bus.flush), 32'd0);
    for (int i = 1; i < 5; i++) begin
      resolve(16'h0040 + 16'(i), 0, 0, 16'h0000); step(); idle();
      check("t3_order_flush", 32'(bus.flush), 32'd0);
    end
    check("t3_empty", 32'(bus.pred_full), 32'd0);
    check("t3_seq", 32'(bus.seq_err), 32'd0);

    // 4: update back-pressure
    push(16'h0060, 16'h0061); step(); idle();
    bus.upd_ready = 0;
    resolve(16'h0060, 1, 0, 16'h0070); step(); idle();
    check("t4_uv", 32'(bus.upd_valid), 32'd1);
    check("t4_ready", 32'(bus.resolve_ready), 32'd0);
    push(16'h0062, 16'h0063); step(); idle();
    resolve(16'h0062, 1, 1, 16'h0080);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_index", 32'(bus.upd_index), 32'h60);
      check("t4_hold_target", 32'(bus.upd_target), 32'h0070);
      check("t4_hold_bc", 32'(bus.branch_count), 32'd2);
    end
    bus.upd_ready = 1; step(); idle();
    check("t4_new_index", 32'(bus.upd_index), 32'h62);
    check("t4_new_taken", 32'(bus.upd_taken), 32'd1);
    check("t4_redirect", 32'(bus.redirect_PC), 32'h0080);
    check("t4_mc", 32'(bus.mispredict_count), 32'd2);
    step();

    // 5: sequencing errors
    resolve(16'h0090, 0, 0, 16'h0000); step(); idle();
    check("t5_seq", 32'(bus.seq_err), 32'd1);
    check("t5_flush", 32'(bus.flush), 32'd1);
    check("t5_redirect", 32'(bus.redirect_PC), 32'h0091);
    step();
    check("t5_sticky", 32'(bus.seq_err), 32'd1);
    push(16'h00A0, 16'h00A1); step(); idle();
    resolve(16'h00B0, 1, 0, 16'h0000); step(); idle();
    check("t5b_flush", 32'(bus.flush), 32'd1);
    check("t5b_redirect", 32'(bus.redirect_PC), 32'h00B1);
    check("t5b_mc", 32'(bus.mispredict_count), 32'd4);
    step();

    // 6: async reset with pending update and 3 queued entries
    for (int i = 0; i < 4; i++) begin
      push(16'h00C0 + 16'(i), 16'h00C1 + 16'(i)); step();
    end
    idle();
    bus.upd_ready = 0;
    resolve(16'h00C0, 1, 0, 16'h0000); step(); idle();
    check("t6_uv_pre", 32'(bus.upd_valid), 32'd1);
    #2 reset_n = 0;
    #1;
    check("t6_flush", 32'(bus.flush), 32'd0);
    check("t6_uv", 32'(bus.upd_valid), 32'd0);
    check("t6_full", 32'(bus.pred_full), 32'd0);
    check("t6_ready", 32'(bus.resolve_ready), 32'd1);
    check("t6_seq", 32'(bus.seq_err), 32'd0);
    check("t6_bc", 32'(bus.branch_count), 32'd0);
    check("t6_mc", 32'(bus.mispredict_count), 32'd0);
    check("t6_index", 32'(bus.upd_index), 32'd0);
    step();
    reset_n = 1;
    bus.upd_ready = 1;
    step();
    resolve(16'h00C1, 0, 0, 16'h0000); step(); idle();
    check("t6_queue_cleared", 32'(bus.seq_err), 32'd1);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
